// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-axis VGA timing generator with frame-boundary reconfiguration.
// Counters advance on pixel ticks. Sync, blank and coordinate outputs are registered
// and lag the counters by one tick. A pending config is applied or rejected only at
// a frame wrap.
module vga_timing_gen #(
  parameter int CW      = 12,
  parameter int H_VIS   = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_VIS   = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          P_CLK,
  input  logic [CW-1:0] CFG_H_VIS,
  input  logic [CW-1:0] CFG_V_VIS,
  input  logic [7:0]    CFG_H_FRONT,
  input  logic [7:0]    CFG_H_SYNC,
  input  logic [7:0]    CFG_H_BACK,
  input  logic [7:0]    CFG_V_FRONT,
  input  logic [7:0]    CFG_V_SYNC,
  input  logic [7:0]    CFG_V_BACK,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  output logic          CFG_ERR,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          ACTIVE,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          LINE_START,
  output logic          FRAME_START
);

  // One axis worth of timing: visible size plus porch/sync lengths
  typedef struct packed {
    logic [CW-1:0] vis;
    logic [7:0]    front;
    logic [7:0]    sync;
    logic [7:0]    back;
  } axis_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} cfg_state_t;

  localparam axis_t RST_H = {CW'(H_VIS), 8'(H_FRONT), 8'(H_SYNC), 8'(H_BACK)};
  localparam axis_t RST_V = {CW'(V_VIS), 8'(V_FRONT), 8'(V_SYNC), 8'(V_BACK)};
  localparam logic [CW:0] MAX_TOTAL = {1'b1, {CW{1'b0}}};

  // Axis total at CW+1 bits so that 2^CW itself is representable
  function automatic logic [CW:0] total_f(input axis_t a);
    return (CW+1)'(a.vis) + (CW+1)'(a.front) + (CW+1)'(a.sync) + (CW+1)'(a.back);
  endfunction

  // An axis is usable when it has visible and sync length and fits the counter
  function automatic logic legal_f(input axis_t a);
    return (a.vis != {CW{1'b0}}) && (a.sync != 8'd0) && (total_f(a) <= MAX_TOTAL);
  endfunction

  // Sync window covers [vis+front, vis+front+sync)
  function automatic logic sync_on_f(input logic [CW-1:0] c, input axis_t a);
    logic [CW:0] s_beg;
    logic [CW:0] s_end;
    s_beg = (CW+1)'(a.vis) + (CW+1)'(a.front);
    s_end = s_beg + (CW+1)'(a.sync);
    return ({1'b0, c} >= s_beg) && ({1'b0, c} < s_end);
  endfunction

  cfg_state_t    state_r, state_nxt_s;
  axis_t         cur_h_r, cur_v_r, pend_h_r, pend_v_r;
  logic [CW-1:0] h_r, v_r;
  logic          capture_s, apply_s, reject_s;
  logic [CW:0]   h_total_s, v_total_s;
  logic          h_last_s, v_last_s, frame_wrap_s;
  logic          active_s, hs_on_s, vs_on_s;
  logic          hsync_r, vsync_r, active_r, line_start_r, frame_start_r;
  logic [CW-1:0] x_r, y_r;
  logic          cfg_ready_r, cfg_err_r;

  assign h_total_s    = total_f(cur_h_r);
  assign v_total_s    = total_f(cur_v_r);
  assign h_last_s     = ({1'b0, h_r} == (h_total_s - (CW+1)'(1)));
  assign v_last_s     = ({1'b0, v_r} == (v_total_s - (CW+1)'(1)));
  assign frame_wrap_s = P_CLK && h_last_s && v_last_s;
  assign active_s     = (h_r < cur_h_r.vis) && (v_r < cur_v_r.vis);
  assign hs_on_s      = sync_on_f(h_r, cur_h_r);
  assign vs_on_s      = sync_on_f(v_r, cur_v_r);

  // Config FSM next state: capture when idle, resolve the pending config at a frame wrap
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    apply_s     = 1'b0;
    reject_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (CFG_VALID) begin
          state_nxt_s = ST_PEND;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (frame_wrap_s) begin
          state_nxt_s = ST_IDLE;
          if (legal_f(pend_h_r) && legal_f(pend_v_r)) begin
            apply_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Config FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending/active timing registers and the handshake status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_h_r     <= RST_H;
      cur_v_r     <= RST_V;
      pend_h_r    <= {(CW+24){1'b0}};
      pend_v_r    <= {(CW+24){1'b0}};
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
    end else begin
      cfg_ready_r <= (state_nxt_s == ST_IDLE);
      cfg_err_r   <= reject_s;
      if (capture_s) begin
        pend_h_r <= {CFG_H_VIS, CFG_H_FRONT, CFG_H_SYNC, CFG_H_BACK};
        pend_v_r <= {CFG_V_VIS, CFG_V_FRONT, CFG_V_SYNC, CFG_V_BACK};
      end
      if (apply_s) begin
        cur_h_r <= pend_h_r;
        cur_v_r <= pend_v_r;
      end
    end
  end

  // Raster counters: h wraps at the line end, v steps on each h wrap; a frame wrap lands on (0,0)
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_r <= {CW{1'b0}};
      v_r <= {CW{1'b0}};
    end else if (P_CLK) begin
      if (h_last_s) begin
        h_r <= {CW{1'b0}};
        if (v_last_s) begin
          v_r <= {CW{1'b0}};
        end else begin
          v_r <= v_r + CW'(1);
        end
      end else begin
        h_r <= h_r + CW'(1);
      end
    end
  end

  // Timing outputs capture the decode of the pre-advance counters on each tick
  always_ff @(posedge CLK) begin
    if (RST) begin
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      active_r      <= 1'b0;
      x_r           <= {CW{1'b0}};
      y_r           <= {CW{1'b0}};
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (P_CLK) begin
      hsync_r       <= hs_on_s ? HS_POL : ~HS_POL;
      vsync_r       <= vs_on_s ? VS_POL : ~VS_POL;
      active_r      <= active_s;
      x_r           <= active_s ? h_r : {CW{1'b0}};
      y_r           <= active_s ? v_r : {CW{1'b0}};
      line_start_r  <= (h_r == {CW{1'b0}});
      frame_start_r <= (h_r == {CW{1'b0}}) && (v_r == {CW{1'b0}});
    end
  end

  assign HSYNC       = hsync_r;
  assign VSYNC       = vsync_r;
  assign ACTIVE      = active_r;
  assign X           = x_r;
  assign Y           = y_r;
  assign LINE_START  = line_start_r;
  assign FRAME_START = frame_start_r;
  assign CFG_READY   = cfg_ready_r;
  assign CFG_ERR     = cfg_err_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: random and directed stimulus checked every CLK against
// a reference model that tracks the raster as a linear position within the frame.
module tb_vga_timing_gen;

  localparam int CW     = 12;
  localparam int P_HV   = 40;
  localparam int P_HF   = 4;
  localparam int P_HS   = 6;
  localparam int P_HB   = 6;
  localparam int P_VV   = 10;
  localparam int P_VF   = 2;
  localparam int P_VS   = 2;
  localparam int P_VB   = 3;
  localparam bit P_HPOL = 1'b0;
  localparam bit P_VPOL = 1'b1;

  logic          CLK = 1'b0;
  logic          RST, P_CLK, CFG_VALID;
  logic [CW-1:0] CFG_H_VIS, CFG_V_VIS;
  logic [7:0]    CFG_H_FRONT, CFG_H_SYNC, CFG_H_BACK, CFG_V_FRONT, CFG_V_SYNC, CFG_V_BACK;
  logic          CFG_READY, CFG_ERR, HSYNC, VSYNC, ACTIVE, LINE_START, FRAME_START;
  logic [CW-1:0] X, Y;

  int req [8];
  int par [8];
  int cur [8];
  int pnd [8];
  bit pnd_v;
  int pos;
  bit e_hs, e_vs, e_act, e_ls, e_fs, e_rdy, e_err;
  int e_x, e_y;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  assign CFG_H_VIS   = CW'(req[0]);
  assign CFG_H_FRONT = 8'(req[1]);
  assign CFG_H_SYNC  = 8'(req[2]);
  assign CFG_H_BACK  = 8'(req[3]);
  assign CFG_V_VIS   = CW'(req[4]);
  assign CFG_V_FRONT = 8'(req[5]);
  assign CFG_V_SYNC  = 8'(req[6]);
  assign CFG_V_BACK  = 8'(req[7]);

  vga_timing_gen #(
    .CW(CW), .H_VIS(P_HV), .H_FRONT(P_HF), .H_SYNC(P_HS), .H_BACK(P_HB),
    .V_VIS(P_VV), .V_FRONT(P_VF), .V_SYNC(P_VS), .V_BACK(P_VB),
    .HS_POL(P_HPOL), .VS_POL(P_VPOL)
  ) dut (
    .CLK(CLK), .RST(RST), .P_CLK(P_CLK),
    .CFG_H_VIS(CFG_H_VIS), .CFG_V_VIS(CFG_V_VIS),
    .CFG_H_FRONT(CFG_H_FRONT), .CFG_H_SYNC(CFG_H_SYNC), .CFG_H_BACK(CFG_H_BACK),
    .CFG_V_FRONT(CFG_V_FRONT), .CFG_V_SYNC(CFG_V_SYNC), .CFG_V_BACK(CFG_V_BACK),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_ERR(CFG_ERR),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .ACTIVE(ACTIVE), .X(X), .Y(Y),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pend_legal();
    int ht, vt;
    ht = pnd[0] + pnd[1] + pnd[2] + pnd[3];
    vt = pnd[4] + pnd[5] + pnd[6] + pnd[7];
    return (pnd[0] != 0) && (pnd[2] != 0) && (pnd[4] != 0) && (pnd[6] != 0)
           && (ht <= 4096) && (vt <= 4096);
  endfunction

  // Reference model: advance one CLK edge using the sampled inputs
  task automatic model_edge();
    int ht, vt, h, v;
    bit old_pv, wrap;
    if (RST) begin
      cur = par; pos = 0; pnd_v = 1'b0;
      e_hs = !P_HPOL; e_vs = !P_VPOL; e_act = 1'b0; e_x = 0; e_y = 0;
      e_ls = 1'b0; e_fs = 1'b0; e_rdy = 1'b1; e_err = 1'b0;
    end else begin
      ht = cur[0] + cur[1] + cur[2] + cur[3];
      vt = cur[4] + cur[5] + cur[6] + cur[7];
      old_pv = pnd_v;
      e_err = 1'b0;
      wrap = P_CLK && (pos == ht * vt - 1);
      if (P_CLK) begin
        h = pos % ht;
        v = pos / ht;
        e_act = (h < cur[0]) && (v < cur[4]);
        e_x = e_act ? h : 0;
        e_y = e_act ? v : 0;
        e_hs = (h >= cur[0] + cur[1] && h < cur[0] + cur[1] + cur[2]) ? P_HPOL : !P_HPOL;
        e_vs = (v >= cur[4] + cur[5] && v < cur[4] + cur[5] + cur[6]) ? P_VPOL : !P_VPOL;
        e_ls = (h == 0);
        e_fs = (pos == 0);
        pos = (pos + 1) % (ht * vt);
      end
      if (old_pv && wrap) begin
        if (pend_legal()) cur = pnd;
        else e_err = 1'b1;
        pnd_v = 1'b0;
      end else if (!old_pv && CFG_VALID) begin
        pnd = req;
        pnd_v = 1'b1;
      end
      e_rdy = !pnd_v;
    end
  endtask

  task automatic compare();
    check_val("HSYNC", 32'(HSYNC), 32'(e_hs));
    check_val("VSYNC", 32'(VSYNC), 32'(e_vs));
    check_val("ACTIVE", 32'(ACTIVE), 32'(e_act));
    check_val("X", 32'(X), e_x);
    check_val("Y", 32'(Y), e_y);
    check_val("LINE_START", 32'(LINE_START), 32'(e_ls));
    check_val("FRAME_START", 32'(FRAME_START), 32'(e_fs));
    check_val("CFG_READY", 32'(CFG_READY), 32'(e_rdy));
    check_val("CFG_ERR", 32'(CFG_ERR), 32'(e_err));
  endtask

  // One CLK: model steps on the rising edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic set_req(input int a0, a1, a2, a3, a4, a5, a6, a7);
    req[0] = a0; req[1] = a1; req[2] = a2; req[3] = a3;
    req[4] = a4; req[5] = a5; req[6] = a6; req[7] = a7;
  endtask

  task automatic submit();
    CFG_VALID = 1'b1;
    cycle();
    CFG_VALID = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    for (int i = 0; i < budget && CFG_READY !== 1'b1; i++) cycle();
    check_val(tag, 32'(CFG_READY), 32'd1);
  endtask

  task automatic random_req();
    int kind;
    kind = int'($urandom_range(0, 4));
    case (kind)
      0: set_req(8, 2, 3, 1, 4, 1, 1, 1);
      1: set_req(int'($urandom_range(1, 20)), int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
                 int'($urandom_range(1, 2)), int'($urandom_range(0, 2)));
      2: set_req(8, 2, 0, 1, 4, 1, 1, 1);
      3: set_req(8, 2, 3, 1, 0, 1, 1, 1);
      default: set_req(4000, 30, 30, 37, 2, 1, 1, 1);
    endcase
  endtask

  initial begin
    int cnt_a, cnt_h, cnt_f, ht_now;
    par[0] = P_HV; par[1] = P_HF; par[2] = P_HS; par[3] = P_HB;
    par[4] = P_VV; par[5] = P_VF; par[6] = P_VS; par[7] = P_VB;
    set_req(8, 2, 3, 1, 4, 1, 1, 1);
    RST = 1'b1; P_CLK = 1'b0; CFG_VALID = 1'b0;
    cycle();
    cycle();
    check_val("rst_ready", 32'(CFG_READY), 32'd1);
    check_val("rst_hsync", 32'(HSYNC), 32'(!P_HPOL));

    // Parameter timing, P_CLK held high: HSYNC active P_HS ticks per line
    RST = 1'b0; P_CLK = 1'b1;
    cycle();
    check_val("first_tick_fs", 32'(FRAME_START), 32'd1);
    cnt_h = 0;
    for (int i = 0; i < 56; i++) begin
      cycle();
      if (HSYNC == P_HPOL) cnt_h++;
    end
    check_val("def_hsync_len", cnt_h, P_HS);

    // Small config applied at the next frame wrap
    set_req(8, 2, 3, 1, 4, 1, 1, 1);
    submit();
    check_val("ready_fall", 32'(CFG_READY), 32'd0);
    wait_ready("small_ready", 2500);
    cnt_a = 0; cnt_f = 0; cnt_h = 0;
    for (int i = 0; i < 98; i++) begin
      cycle();
      if (ACTIVE) cnt_a++;
      if (FRAME_START) cnt_f++;
      if (i < 14 && HSYNC == P_HPOL) cnt_h++;
    end
    check_val("small_active", cnt_a, 32);
    check_val("small_fs", cnt_f, 1);
    check_val("small_hsync", cnt_h, 3);

    // Tick every 4th CLK: every interval stretches by 4
    cnt_a = 0;
    for (int i = 0; i < 392; i++) begin
      P_CLK = (i % 4 == 0);
      cycle();
      if (ACTIVE) cnt_a++;
    end
    check_val("slow_active", cnt_a, 128);
    P_CLK = 1'b1;

    // Handshake on the frame-wrap edge: old timing runs one more full frame
    for (int i = 0; i < 200 && pos != 97; i++) cycle();
    set_req(10, 1, 2, 1, 5, 1, 1, 1);
    submit();
    check_val("wrap_hs_ready", 32'(CFG_READY), 32'd0);
    cnt_a = 0;
    for (int i = 0; i < 98; i++) begin
      cycle();
      if (ACTIVE) cnt_a++;
    end
    check_val("wrap_hs_old_active", cnt_a, 32);
    check_val("wrap_hs_ready_back", 32'(CFG_READY), 32'd1);

    // Zero H_SYNC: accepted, then rejected at the wrap
    set_req(8, 2, 0, 1, 4, 1, 1, 1);
    submit();
    check_val("err_accept", 32'(CFG_READY), 32'd0);
    for (int i = 0; i < 300 && CFG_ERR !== 1'b1; i++) cycle();
    check_val("err_pulse", 32'(CFG_ERR), 32'd1);
    check_val("err_ready", 32'(CFG_READY), 32'd1);
    cycle();
    check_val("err_one_clk", 32'(CFG_ERR), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 12000; i++) begin
      P_CLK = ($urandom_range(0, 2) != 0);
      RST = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 49) == 0) begin
        random_req();
        CFG_VALID = 1'b1;
      end else begin
        CFG_VALID = 1'b0;
      end
      cycle();
    end
    RST = 1'b0; CFG_VALID = 1'b0; P_CLK = 1'b1;
    wait_ready("rand_drain", 3000);

    // Reset mid-line at (5,2) while a config is pending
    for (int i = 0; i < 3000 && pos != 0; i++) cycle();
    set_req(8, 2, 3, 1, 4, 1, 1, 1);
    submit();
    ht_now = cur[0] + cur[1] + cur[2] + cur[3];
    for (int i = 0; i < 3000 && pos != 2 * ht_now + 5; i++) cycle();
    check_val("pend_before_rst", 32'(CFG_READY), 32'd0);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    check_val("rst_mid_ready", 32'(CFG_READY), 32'd1);
    check_val("rst_mid_active", 32'(ACTIVE), 32'd0);
    cycle();
    check_val("rst_mid_restart", 32'(FRAME_START), 32'd1);

    // Boundary: total of exactly 2^CW is legal
    set_req(4000, 30, 30, 36, 1, 1, 1, 0);
    submit();
    wait_ready("max_ready", 1500);
    for (int i = 0; i < 4096 * 3 + 50; i++) cycle();
    check_val("max_no_err", 32'(CFG_ERR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised two-axis VGA timing generator: horizontal and vertical counters, sync, blanking and pixel coordinates for one display. It replaces the single-axis sync calculator pair in the VGA path. Timing is set at build time by parameters and can be reprogrammed at runtime through a valid/ready config port. New timing takes effect only on a frame boundary, so the display never sees a torn frame.

## Interface
- CW, 12: width of counters, coordinates and visible-size fields
- H_VIS / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48: reset horizontal timing, in pixels
- V_VIS / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33: reset vertical timing, in lines
- HS_POL, 0: HSYNC active level (0 = active-low)
- VS_POL, 0: VSYNC active level

- CLK  in  1  system clock; all logic on its rising edge
- RST  in  1  synchronous reset, active-high
- P_CLK  in  1  pixel-tick enable, one CLK wide; counters and timing outputs advance only when it is high
- CFG_H_VIS, CFG_V_VIS  in  CW  requested visible size
- CFG_H_FRONT, CFG_H_SYNC, CFG_H_BACK, CFG_V_FRONT, CFG_V_SYNC, CFG_V_BACK  in  8 each  requested porch and sync lengths
- CFG_VALID  in  1  config request
- CFG_READY  out  1  config slot free
- CFG_ERR  out  1  one-CLK pulse when an accepted config is rejected
- HSYNC, VSYNC  out  1  sync outputs, polarity set by HS_POL / VS_POL
- ACTIVE  out  1  pixel is inside the visible area
- X, Y  out  CW  pixel coordinate while ACTIVE, 0 otherwise
- LINE_START  out  1  high for the tick at h = 0
- FRAME_START  out  1  high for the tick at h = 0 and v = 0

## Operation
- Each line runs in this order: visible, front porch, sync, back porch. Frames follow the same order.
  - H_TOTAL = H_VIS + H_FRONT + H_SYNC + H_BACK; V_TOTAL is formed the same way.
  - Sums are computed at CW+1 bits. A legal config has a total of at most 2^CW.
- Counter h runs from 0 to H_TOTAL-1 and wraps to 0. v increments on every h wrap and wraps at V_TOTAL-1.
- Decode, evaluated on the current counter values (h, v):
  - ACTIVE = (h < H_VIS) and (v < V_VIS)
  - X = h if ACTIVE, else 0; Y = v if ACTIVE, else 0
  - HSYNC is at its active level when H_VIS+H_FRONT ≤ h < H_VIS+H_FRONT+H_SYNC.
  - VSYNC uses the same rule on v and is independent of h.
- Config state machine, two states:
  - IDLE: CFG_READY = 1.
  - PEND: CFG_READY = 0.
  - IDLE to PEND when CFG_VALID and CFG_READY are both high at a CLK edge. The fields are captured into a pending register.
  - Capture happens regardless of P_CLK.
- A capture and a frame wrap can fall on the same edge. In that case the captured config is not applied at that wrap; it waits for the next one.
- Frame wrap is the tick where h = H_TOTAL-1 and v = V_TOTAL-1. When in PEND at a frame wrap:
  - If the pending config is legal: it becomes the active timing and the counters restart at (0,0) with it. State returns to IDLE.
  - If it is illegal (any VIS or SYNC field = 0, or a total > 2^CW): it is dropped, CFG_ERR pulses for one CLK, and state returns to IDLE.
- RST loads the parameter timing, sets h = v = 0 and clears the pending register. It overrides any transfer or tick on the same edge.

## Timing
- All outputs are registered. On a tick, the output registers load the decode of the pre-advance (h, v), then the counters advance. Outputs therefore lag the counters by one tick.
- Reset values:
  - HSYNC = ~HS_POL, VSYNC = ~VS_POL
  - ACTIVE = 0, X = 0, Y = 0
  - LINE_START = 0, FRAME_START = 0
  - CFG_READY = 1, CFG_ERR = 0
- First tick after reset: outputs show ACTIVE = 1, X = 0, Y = 0, LINE_START = 1, FRAME_START = 1.
- LINE_START and FRAME_START are high from one tick edge to the next. They are not one-CLK pulses.
- Timing outputs hold their value on CLK edges where P_CLK = 0.
- CFG_READY falls on the edge after the handshake. It rises on the edge after the applying frame wrap, in the same cycle as CFG_ERR if the config was rejected. A new handshake is possible from that edge on.
- Line period = H_TOTAL ticks. Frame period = H_TOTAL × V_TOTAL ticks.

## Test plan
- Reset defaults with P_CLK held high: HSYNC is low (active) for exactly 96 ticks per 800-tick line. VSYNC is low for exactly 2 lines per 525-line frame. FRAME_START repeats every 420000 ticks.
- Small config H 8/2/3/1, V 4/1/1/1, applied after one default frame:
  - H_TOTAL = 14, V_TOTAL = 7.
  - X runs 0..7 then 0 for 6 ticks.
  - HSYNC is active on h = 10..12.
  - ACTIVE is high for 8 × 4 = 32 ticks per 98-tick frame.
- P_CLK high only every 4th CLK, small config: all timing outputs change only on enabled edges. Every interval is 4× longer in CLK cycles, with no other change.
- Handshake on the exact frame-wrap edge: the old timing persists for one more full frame. CFG_READY stays 0 until the following wrap, then returns to 1.
- Config with H_SYNC = 0: accepted (CFG_READY falls). At the wrap CFG_ERR pulses for 1 CLK, CFG_READY = 1 and the previous timing continues unchanged.
- RST asserted mid-line (h = 5, v = 2) in PEND state: the next edge gives reset output values and CFG_READY = 1, and the parameter timing resumes from (0,0).
